// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared constants and the hex-to-7-segment decode used by the display paths.
// Segment patterns are active-low, bit order g,f,e,d,c,b,a.
package seg7_scan_ctrl_pkg;

   localparam logic [7:0] SEG_OFF          = 8'hFF;
   localparam logic [3:0] AN_OFF           = 4'hF;
   localparam int         SCAN_DIV_DEFAULT = 50000;

   function automatic logic [6:0] hex7(input logic [3:0] nib);
      logic [6:0] pat;
      pat = 7'h7F;
      case (nib)
         4'h0: pat = 7'h40;
         4'h1: pat = 7'h79;
         4'h2: pat = 7'h24;
         4'h3: pat = 7'h30;
         4'h4: pat = 7'h19;
         4'h5: pat = 7'h12;
         4'h6: pat = 7'h02;
         4'h7: pat = 7'h78;
         4'h8: pat = 7'h00;
         4'h9: pat = 7'h10;
         4'hA: pat = 7'h08;
         4'hB: pat = 7'h03;
         4'hC: pat = 7'h46;
         4'hD: pat = 7'h21;
         4'hE: pat = 7'h06;
         4'hF: pat = 7'h0E;
         default: pat = 7'h7F;
      endcase
      return pat;
   endfunction

endpackage

// File: rtl/seg7_scan_ctrl_hex.sv
// Combinational nibble to active-low 7-segment pattern (g,f,e,d,c,b,a).
module hex_to_seg7
   import seg7_scan_ctrl_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] seg
);

   always_comb begin
      seg = hex7(nib);
   end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed 7-segment scanner; display data is shadowed once per
// frame so a digit never mixes old and new values within one scan.
module seg7_scan_ctrl
   import seg7_scan_ctrl_pkg::*;
#(
   parameter int SCAN_DIV = SCAN_DIV_DEFAULT,
   parameter int CNT_W    = 16
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [15:0] disp_data,
   input  logic [3:0]  dp,
   input  logic [3:0]  blank,
   output logic [3:0]  an,
   output logic [7:0]  seg,
   output logic        frame_done
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       idx_q, idx_d;
   logic [15:0]      data_s_q, data_s_d;
   logic [3:0]       dp_s_q, dp_s_d;
   logic [3:0]       blank_s_q, blank_s_d;
   logic [3:0]       an_q, an_d;
   logic [7:0]       seg_q, seg_d;
   logic             frame_done_q, frame_done_d;
   logic             tick;
   logic [3:0]       nib_s [4];
   logic [6:0]       dec_seg;

   for (genvar gi = 0; gi < 4; gi++) begin : g_nib
      assign nib_s[gi] = data_s_q[gi*4 +: 4];
   end

   hex_to_seg7 u_dec (
      .nib (nib_s[idx_q]),
      .seg (dec_seg)
   );

   always_comb begin
      cnt_d        = cnt_q;
      idx_d        = idx_q;
      data_s_d     = data_s_q;
      dp_s_d       = dp_s_q;
      blank_s_d    = blank_s_q;
      an_d         = AN_OFF;
      seg_d        = SEG_OFF;
      frame_done_d = 1'b0;
      tick         = en && (cnt_q == CNT_LAST);

      if (en) begin
         cnt_d = tick ? '0 : cnt_q + 1'b1;
         if (tick) begin
            idx_d = idx_q + 2'd1;
         end
         // Latch on the last slot of a frame so the next digit0 shows new data.
         if (tick && idx_q == 2'd3) begin
            data_s_d     = disp_data;
            dp_s_d       = dp;
            blank_s_d    = blank;
            frame_done_d = 1'b1;
         end
         an_d  = ~(4'b0001 << idx_q);
         seg_d = blank_s_q[idx_q] ? SEG_OFF : {~dp_s_q[idx_q], dec_seg};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q        <= '0;
         idx_q        <= 2'd0;
         data_s_q     <= 16'h0000;
         dp_s_q       <= 4'h0;
         blank_s_q    <= 4'h0;
         an_q         <= AN_OFF;
         seg_q        <= SEG_OFF;
         frame_done_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         data_s_q     <= data_s_d;
         dp_s_q       <= dp_s_d;
         blank_s_q    <= blank_s_d;
         an_q         <= an_d;
         seg_q        <= seg_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign an         = an_q;
   assign seg        = seg_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with a 4-cycle digit slot; expectations
// are hand-computed per digit slot.
module tb_seg7_scan_ctrl;

   typedef struct {
      logic [15:0] data;
      logic [3:0]  dp;
      logic [3:0]  blank;
      logic [3:0]  an;
      logic [7:0]  seg;
   } slot_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [15:0] disp_data;
   logic [3:0]  dp;
   logic [3:0]  blank;
   logic [3:0]  an;
   logic [7:0]  seg;
   logic        frame_done;

   int n_tests = 0;
   int n_fail  = 0;

   slot_t slots [20];
   logic [7:0]  dec_tab [16];
   logic [3:0]  an_tab  [4];
   logic [15:0] sweep   [5];

   always #5 clk = ~clk;

   seg7_scan_ctrl #(
      .SCAN_DIV (4),
      .CNT_W    (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .disp_data  (disp_data),
      .dp         (dp),
      .blank      (blank),
      .an         (an),
      .seg        (seg),
      .frame_done (frame_done)
   );

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic [3:0] e_an,
                            input logic [7:0] e_seg, input logic e_fd);
      logic one_low;
      one_low = ($countones(~an) <= 1);
      check({tag, " an"},         {4'h0, an},         {4'h0, e_an});
      check({tag, " seg"},        seg,                e_seg);
      check({tag, " frame_done"}, {7'h0, frame_done}, {7'h0, e_fd});
      check({tag, " one_anode"},  {7'h0, one_low},    8'h01);
   endtask

   // Applies the slot's inputs, then checks all four cycles of the slot.
   task automatic run_slot(input string tag, input slot_t s);
      disp_data = s.data;
      dp        = s.dp;
      blank     = s.blank;
      for (int c = 0; c < 4; c++) begin
         step();
         check_out(tag, s.an, s.seg, (s.an == 4'h7) && (c == 3));
      end
      $display("[TB] %s in=%h/%b/%b an=%h seg=%h exp_an=%h exp_seg=%h",
               tag, s.data, s.dp, s.blank, an, seg, s.an, s.seg);
   endtask

   initial begin
      dec_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                  8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
      an_tab  = '{4'hE, 4'hD, 4'hB, 4'h7};
      sweep   = '{16'h3210, 16'h7654, 16'hBA98, 16'hFEDC, 16'h0000};

      // Frame 0 shows the reset shadow; frame 1 shows 8F10; mid-frame change to 1234.
      slots[0]  = '{16'h8F10, 4'b0100, 4'b0000, 4'hE, 8'hC0};
      slots[1]  = '{16'h8F10, 4'b0100, 4'b0000, 4'hD, 8'hC0};
      slots[2]  = '{16'h8F10, 4'b0100, 4'b0000, 4'hB, 8'hC0};
      slots[3]  = '{16'h8F10, 4'b0100, 4'b0000, 4'h7, 8'hC0};
      slots[4]  = '{16'h8F10, 4'b0100, 4'b0000, 4'hE, 8'hC0};
      slots[5]  = '{16'h1234, 4'b0000, 4'b0000, 4'hD, 8'hF9};
      slots[6]  = '{16'h1234, 4'b0000, 4'b0000, 4'hB, 8'h0E};
      slots[7]  = '{16'h1234, 4'b0000, 4'b0000, 4'h7, 8'h80};
      slots[8]  = '{16'h1234, 4'b0000, 4'b1010, 4'hE, 8'h99};
      slots[9]  = '{16'h1234, 4'b0000, 4'b1010, 4'hD, 8'hB0};
      slots[10] = '{16'h1234, 4'b0000, 4'b1010, 4'hB, 8'hA4};
      slots[11] = '{16'h1234, 4'b0000, 4'b1010, 4'h7, 8'hF9};
      slots[12] = '{16'hE5D0, 4'b1000, 4'b0000, 4'hE, 8'h99};
      slots[13] = '{16'hE5D0, 4'b1000, 4'b0000, 4'hD, 8'hFF};
      slots[14] = '{16'hE5D0, 4'b1000, 4'b0000, 4'hB, 8'hA4};
      slots[15] = '{16'hE5D0, 4'b1000, 4'b0000, 4'h7, 8'hFF};
      slots[16] = '{16'hE5D0, 4'b1000, 4'b0000, 4'hE, 8'hC0};
      slots[17] = '{16'hE5D0, 4'b1000, 4'b0000, 4'hD, 8'hA1};
      slots[18] = '{16'hE5D0, 4'b1000, 4'b0000, 4'hB, 8'h92};
      slots[19] = '{16'hE5D0, 4'b1000, 4'b0000, 4'h7, 8'h06};

      rst       = 1'b1;
      en        = 1'b1;
      disp_data = 16'h0000;
      dp        = 4'h0;
      blank     = 4'h0;

      // Reset held with en high: reset wins.
      for (int i = 0; i < 3; i++) begin
         step();
         check_out("reset", 4'hF, 8'hFF, 1'b0);
      end
      rst = 1'b0;

      for (int s = 0; s < 20; s++) begin
         run_slot($sformatf("slot%0d", s), slots[s]);
      end

      // Pause in the middle of the digit2 slot; the remaining count must survive.
      run_slot("hold_d0", '{16'hE5D0, 4'b1000, 4'b0000, 4'hE, 8'hC0});
      run_slot("hold_d1", '{16'hE5D0, 4'b1000, 4'b0000, 4'hD, 8'hA1});
      step(); check_out("hold_d2a", 4'hB, 8'h92, 1'b0);
      step(); check_out("hold_d2b", 4'hB, 8'h92, 1'b0);
      en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         check_out("paused", 4'hF, 8'hFF, 1'b0);
      end
      $display("[TB] pause 10 cycles an=%h seg=%h", an, seg);
      en = 1'b1;
      step(); check_out("resume_d2a", 4'hB, 8'h92, 1'b0);
      step(); check_out("resume_d2b", 4'hB, 8'h92, 1'b0);
      run_slot("resume_d3", '{16'hE5D0, 4'b1000, 4'b0000, 4'h7, 8'h06});
      run_slot("resume_d0", '{16'hE5D0, 4'b1000, 4'b0000, 4'hE, 8'hC0});

      // Reset one cycle before the wrap: no frame_done, shadow cleared.
      run_slot("pre_rst_d1", '{16'hE5D0, 4'b1000, 4'b0000, 4'hD, 8'hA1});
      run_slot("pre_rst_d2", '{16'hE5D0, 4'b1000, 4'b0000, 4'hB, 8'h92});
      for (int i = 0; i < 3; i++) begin
         step();
         check_out("pre_rst_d3", 4'h7, 8'h06, 1'b0);
      end
      rst = 1'b1;
      step();
      check_out("mid_rst", 4'hF, 8'hFF, 1'b0);
      $display("[TB] reset at wrap an=%h seg=%h frame_done=%b", an, seg, frame_done);
      rst = 1'b0;

      for (int i = 0; i < 4; i++) begin
         run_slot($sformatf("post_rst_d%0d", i),
                  '{sweep[0], 4'h0, 4'h0, an_tab[i], 8'hC0});
      end

      // Every nibble through the decoder, four per frame.
      for (int f = 0; f < 4; f++) begin
         for (int i = 0; i < 4; i++) begin
            run_slot($sformatf("sweep_f%0d_d%0d", f, i),
                     '{sweep[f+1], 4'h0, 4'h0, an_tab[i], dec_tab[4*f + i]});
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
